// File: rtl/vga_vram_arbiter_pkg.sv
// vga_vram_arbiter_pkg: shared widths, host FSM encoding and RGB332 helpers
package vga_vram_arbiter_pkg;
    localparam int VGA_ADDR_W = 17;
    localparam int VGA_DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_ACK   = 2'd2
    } host_state_e;

    function automatic logic [7:0] rgb332(input logic [2:0] r, input logic [2:0] g, input logic [1:0] b);
        return {r, g, b};
    endfunction
endpackage

// File: rtl/vga_pix_phase.sv
// vga_pix_phase: pixel phase counter 0..PIX_DIV-1 and the pixel-clock enable
module vga_pix_phase #(
    parameter int PIX_DIV = 4,
    localparam int PW = $clog2(PIX_DIV)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [PW-1:0] phase,
    output logic          pix_ce
);
    logic [PW-1:0] phase_q, phase_d;

    always_comb begin
        phase_d = (phase_q == PW'(PIX_DIV - 1)) ? '0 : phase_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) phase_q <= '0;
        else phase_q <= phase_d;
    end

    // Held low while in reset so the first enable lands on the first cycle after release
    assign phase  = phase_q;
    assign pix_ce = rst && (phase_q == '0);
endmodule

// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: time-slices one sync pixel RAM between VGA scan-out (phase 0) and a host req/ack port
module vga_vram_arbiter
    import vga_vram_arbiter_pkg::*;
#(
    parameter int PIX_DIV = 4,
    parameter int ADDR_W  = VGA_ADDR_W,
    parameter int DATA_W  = VGA_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              pix_ce,
    input  logic              disp_active,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] pix_data,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int PW = $clog2(PIX_DIV);

    logic [PW-1:0] phase;
    host_state_e   state_q, state_d;
    logic          flag_q, flag_d;
    logic [DATA_W-1:0] pix_q, pix_d, rdata_q, rdata_d;
    logic          issue, disp;

    vga_pix_phase #(.PIX_DIV(PIX_DIV)) u_phase (
        .clk    (clk),
        .rst    (rst),
        .phase  (phase),
        .pix_ce (pix_ce)
    );

    // An issue launched from the last phase would collide with the display slot, so it waits
    always_comb begin
        state_d   = (state_q == S_ISSUE) ? S_ACK
                  : (state_q == S_IDLE && host_req && phase != PW'(PIX_DIV - 1)) ? S_ISSUE : S_IDLE;
        issue     = rst && (state_q == S_ISSUE);
        disp      = pix_ce && disp_active;
        host_ack  = rst && (state_q == S_ACK);
        mem_en    = issue || disp;
        mem_we    = issue && host_we;
        mem_addr  = issue ? host_addr : disp ? disp_addr : '0;
        mem_wdata = issue ? host_wdata : '0;
        flag_d    = pix_ce ? disp_active : flag_q;
        pix_d     = (phase == PW'(1)) ? (flag_q ? mem_rdata : '0) : pix_q;
        rdata_d   = (host_ack && !host_we) ? mem_rdata : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            flag_q  <= 1'b0;
            pix_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            pix_q   <= pix_d;
            rdata_q <= rdata_d;
        end
    end

    // Read data is forwarded during the ack cycle, then held by the register
    assign pix_data   = pix_q;
    assign host_rdata = rdata_d;
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb_vga_vram_arbiter: random display/host traffic checked against a slot-schedule model
module tb_vga_vram_arbiter;
    localparam int PD = 4;
    localparam int AW = 17;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pix_ce;
    logic          disp_active = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic [DW-1:0] pix_data;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int total = 0;
    int bad = 0;
    int t = 0;
    int gap = 0;
    int ntx = 0;
    int iss = 0;
    bit busy = 0;
    logic          hwe;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hwd;
    logic [DW-1:0] last_rd, pend_pix, cur_pix;
    logic [DW-1:0] gold [int];

    always #5 clk = ~clk;

    vga_vram_arbiter #(.PIX_DIV(PD), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_ce      (pix_ce),
        .disp_active (disp_active),
        .disp_addr   (disp_addr),
        .pix_data    (pix_data),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ack    (host_ack),
        .host_rdata  (host_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == AW'(17'h10)) ? 8'hE5 : (a[7:0] ^ a[15:8] ^ 8'h5A);
    endfunction

    logic [DW-1:0] ram [0:(1<<AW)-1];
    bit            wr  [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                wr[mem_addr]  <= 1'b1;
            end else begin
                mem_rdata <= wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
            end
        end
    end

    function automatic logic [DW-1:0] gold_rd(input logic [AW-1:0] a);
        return gold.exists(int'(a)) ? gold[int'(a)] : init_val(a);
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        return ($urandom_range(0, 7) == 0) ? AW'(17'h1FFFF) : AW'($urandom_range(0, 15));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    task automatic reset_seq(input int n);
        for (int i = 0; i < n; i++) begin
            rst = 1'b0;
            host_req = 1'b1;
            host_we = 1'($urandom_range(0, 1));
            host_addr = pick_addr();
            host_wdata = DW'($urandom);
            disp_active = 1'b1;
            disp_addr = pick_addr();
            @(negedge clk);
            chk("rst_pix_ce", 32'(pix_ce), 32'd0);
            chk("rst_mem_en", 32'(mem_en), 32'd0);
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
            chk("rst_ack", 32'(host_ack), 32'd0);
            chk("rst_pix_data", 32'(pix_data), 32'd0);
            chk("rst_rdata", 32'(host_rdata), 32'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        host_req = 1'b0;
        t = 0;
        busy = 0;
        cur_pix = '0;
        pend_pix = '0;
        last_rd = '0;
        gap = int'($urandom_range(0, 3));
    endtask

    task automatic run(input int n, input bit rst_mid);
        int  ph;
        bit  is_iss, is_ack, ds;
        for (int k = 0; k < n; k++) begin
            ph = t % PD;
            if (t == 0) begin
                disp_active = 1'b1;
                disp_addr = AW'(17'h10);
            end else begin
                disp_active = ($urandom_range(0, 3) != 0);
                disp_addr = pick_addr();
            end
            if (!busy) begin
                if (gap > 0) begin
                    gap--;
                    host_req = 1'b0;
                end else if (ntx == 2 && ph != PD - 1) begin
                    host_req = 1'b0;
                end else begin
                    busy = 1;
                    hwe = (ntx == 0) ? 1'b1 : (ntx == 1) ? 1'b0 : 1'($urandom_range(0, 1));
                    haddr = (ntx < 2) ? AW'(17'h1FFFF) : pick_addr();
                    hwd = (ntx == 0) ? 8'h3C : DW'($urandom);
                    host_req = 1'b1;
                    host_we = hwe;
                    host_addr = haddr;
                    host_wdata = hwd;
                    iss = (ph != PD - 1) ? t + 1 : t + 2;
                end
            end
            if (rst_mid && busy && t == iss) begin
                rst = 1'b0;
                @(negedge clk);
                chk("mid_mem_en", 32'(mem_en), 32'd0);
                chk("mid_ack", 32'(host_ack), 32'd0);
                @(posedge clk);
                #1;
                return;
            end
            @(negedge clk);
            is_iss = busy && (t == iss);
            is_ack = busy && (t == iss + 1);
            ds = (ph == 0) && disp_active;
            chk("pix_ce", 32'(pix_ce), 32'(ph == 0));
            chk("mem_en", 32'(mem_en), 32'(is_iss || ds));
            chk("mem_we", 32'(mem_we), 32'(is_iss && hwe));
            chk("mem_addr", 32'(mem_addr), 32'(is_iss ? haddr : ds ? disp_addr : '0));
            chk("mem_wdata", 32'(mem_wdata), 32'(is_iss ? hwd : '0));
            chk("host_ack", 32'(host_ack), 32'(is_ack));
            if (is_ack) begin
                if (hwe) gold[int'(haddr)] = hwd;
                else last_rd = gold_rd(haddr);
                busy = 0;
                gap = int'($urandom_range(0, 5));
                ntx++;
            end
            chk("host_rdata", 32'(host_rdata), 32'(last_rd));
            if (ph == 0) pend_pix = disp_active ? gold_rd(disp_addr) : '0;
            if (ph == 2) cur_pix = pend_pix;
            chk("pix_data", 32'(pix_data), 32'(cur_pix));
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        reset_seq(3);
        run(3000, 1'b0);
        run(400, 1'b1);
        reset_seq(2);
        run(500, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
